uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Sequencing controller for the UART receiver. It tracks the incoming frame using an oversampling edge counter and a bit counter, and walks the frame through start, data, optional parity and stop phases. It issues one-cycle enables to the data sampler, deserializer and start/parity/stop checkers, and raises `data_valid` only for clean frames. It sits in the RX clock domain between the `RX_IN` pin synchronizer and the checker/deserializer leaf blocks.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `PRESC_W`, 6: width of prescale and edge counter.
- `CLK` in 1: RX oversampling clock.
- `RST` in 1: asynchronous, active-low reset.
- `RX_IN` in 1: synchronized serial line; idle high.
- `PAR_EN` in 1: parity bit present in frame.
- `Prescale` in `PRESC_W`: oversampling ratio. Legal values are 8, 16 and 32; any other value gives undefined behaviour.
- `strt_glitch` in 1: registered start-check result; 1 = false start.
- `par_err` in 1: registered parity-check result.
- `stp_err` in 1: registered stop-check result.
- `edge_cnt` out `PRESC_W`: oversample index within the current bit.
- `bit_cnt` out 4: bit index within the frame.
- `dat_samp_en` out 1: sampler enable.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en` out 1 each: one-cycle checker strobes.
- `deser_en` out 1: one-cycle shift strobe to the deserializer.
- `data_valid` out 1: one-cycle pulse; the frame was received without error.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
- Define HALF = `Prescale`>>1 and LAST = `Prescale`−1.
- IDLE:
  - `edge_cnt` = 0 and `bit_cnt` = 0.
  - `RX_IN` = 0 moves the FSM to START and latches `PAR_EN` into `par_en_q`. `PAR_EN` changes mid-frame are ignored.
- Counters while not in IDLE:
  - `edge_cnt` increments every cycle.
  - At LAST, `edge_cnt` wraps to 0 and `bit_cnt` increments.
- Bit positions:
  - START: `bit_cnt` 0.
  - DATA: `bit_cnt` 1..`DATA_WIDTH`.
  - PARITY: `bit_cnt` `DATA_WIDTH`+1.
  - STOP: `bit_cnt` `DATA_WIDTH`+1, or `DATA_WIDTH`+2 with parity.
- `dat_samp_en` is 1 in every state except IDLE. The sampler takes its samples at HALF−1, HALF and HALF+1.
- Strobes, all asserted at `edge_cnt` = HALF+2:
  - `strt_chk_en` in START.
  - `deser_en` in DATA.
  - `par_chk_en` in PARITY.
  - `stp_chk_en` in STOP.
- Transitions, all evaluated at `edge_cnt` = LAST:
  - START: `strt_glitch` = 1 → IDLE, counters cleared; otherwise → DATA.
  - DATA: at `bit_cnt` = `DATA_WIDTH` → PARITY if `par_en_q`, else → STOP.
  - PARITY → STOP. `par_err` is captured into the sticky `frame_err` and does not abort the frame.
  - STOP → IDLE. `data_valid` pulses if `stp_err` = 0 and `frame_err` = 0.
- `frame_err` clears on entry to START.
- A low `RX_IN` in the cycle STOP exits does not start a frame; IDLE samples the line on the following cycle.
- Reset mid-frame: the FSM returns to IDLE immediately and all outputs go to 0. A partial frame never produces `data_valid`.

## Timing
- Reset values: state IDLE; all outputs, `edge_cnt`, `bit_cnt`, `par_en_q` and `frame_err` are 0.
- State, counters and `data_valid` are registered. Enables and strobes are decoded combinationally from the registered state and `edge_cnt`, with no input-to-output combinational path.
- Error inputs are registered one cycle after their strobe and are read at LAST, which is at least HALF−3 cycles of margin.
- Frame latency: when IDLE sees `RX_IN` = 0 in cycle N, `data_valid` is high only in cycle N+1+B·`Prescale`. B = `DATA_WIDTH`+2, plus 1 with parity.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state, `par_chk_en` and `par_err` handling are compiled in.
- `UART_RX_PARITY_EN` undefined:
  - The `PAR_EN` and `par_err` ports remain but are ignored.
  - `par_chk_en` is tied to 0.
  - `par_en_q` is forced to 0.
  - DATA always proceeds to STOP.

## Structure
- Package `uart_rx_pkg`:
  - State enum `uart_rx_state_t`.
  - Legal prescale constants 8, 16 and 32.
  - Strobe offset constant `CHK_OFS` = 2.
- Sub-module `uart_rx_edge_bit_cnt` holds the edge and bit counters, with enable/clear from the FSM. The FSM and strobe decode stay in `uart_rx_ctrl`.

## Test plan
- Reset: hold `RST` = 0 mid-frame → all outputs 0 and IDLE; the next clean frame is received normally.
- Clean frame, no parity: `Prescale` = 8, `PAR_EN` = 0, frame 0xA5 → exactly 8 `deser_en` pulses, each at `edge_cnt` = 6. `data_valid` is high only at N+81.
- Clean frame, parity: `Prescale` = 16, `PAR_EN` = 1, frame 0x3C → `par_chk_en` once at `bit_cnt` = 9, `edge_cnt` = 10. `data_valid` is high only at N+177.
- False start: 2-sample low pulse with `strt_glitch` = 1 → return to IDLE at START end; no `deser_en`, no `data_valid`.
- Bad parity and bad stop: `par_err` = 1 on one frame, `stp_err` = 1 on the next → both frames complete with no `data_valid`; the following clean frame gives `data_valid`.
- Build without `UART_RX_PARITY_EN` and `PAR_EN` = 1, `Prescale` = 32 → no PARITY state; `data_valid` is high only at N+321.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller slice.
// Holds the state encoding, legal oversampling ratios and the checker strobe offset.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    // Checkers fire two oversamples after mid-bit, once the sampler's 3-sample vote has settled.
    localparam int CHK_OFS = 2;

    function automatic logic presc_legal(input int p);
        return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// Registered, one-cycle update; clear has priority over count enable.
module uart_rx_edge_bit_cnt #(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cnt_en,
    input  logic               cnt_clr,
    input  logic [PRESC_W-1:0] last,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_en) begin
            if (edge_cnt == last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencing FSM: walks start/data/parity/stop, strobes checkers, flags clean frames.
// data_valid lands 1 + bits*Prescale cycles after the start edge; parity support needs UART_RX_PARITY_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               deser_en,
    output logic               data_valid
);

    uart_rx_state_t     state, next_state;
    logic [PRESC_W-1:0] half, last;
    logic               at_last, at_chk, start_det;
    logic               cnt_en, cnt_clr;
    logic               par_en_q, frame_err;

    assign half      = Prescale >> 1;
    assign last      = Prescale - PRESC_W'(1);
    assign at_last   = (edge_cnt == last);
    assign at_chk    = (edge_cnt == half + PRESC_W'(CHK_OFS));
    assign start_det = (state == IDLE) && !RX_IN;

    assign cnt_en  = (state != IDLE);
    assign cnt_clr = (state != IDLE) && (next_state == IDLE);

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .last     (last),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!RX_IN) next_state = START;
            START:  if (at_last) next_state = strt_glitch ? IDLE : DATA;
            DATA:   if (at_last && bit_cnt == 4'(DATA_WIDTH))
                        next_state = par_en_q ? PARITY : STOP;
            PARITY: if (at_last) next_state = STOP;
            STOP:   if (at_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dat_samp_en = (state != IDLE);
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        if (at_chk) begin
            case (state)
                START:  strt_chk_en = 1'b1;
                DATA:   deser_en    = 1'b1;
`ifdef UART_RX_PARITY_EN
                PARITY: par_chk_en  = 1'b1;
`endif
                STOP:   stp_chk_en  = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mode is frozen at the start edge; a bad parity bit only taints the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            frame_err <= 1'b0;
        end else if (start_det) begin
            par_en_q  <= PAR_EN;
            frame_err <= 1'b0;
        end else if (state == PARITY && at_last && par_err) begin
            frame_err <= 1'b1;
        end
    end
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ par_err;
    assign par_en_q   = 1'b0;
    assign frame_err  = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) data_valid <= 1'b0;
        else      data_valid <= (state == STOP) && at_last && !stp_err && !frame_err;
    end

    assert property (@(posedge CLK) disable iff (!RST) presc_legal(int'(Prescale)));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: per-cycle frame tracking plus hand-computed latencies.
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic [PW-1:0] Prescale = PW'(8);
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one frame starting in the current (IDLE) cycle N; k counts cycles after N.
    task automatic run_frame(input int p, input bit pen, input logic [7:0] dat,
                             input bit glitch, input bit perr, input bit serr, input bit early,
                             output int trk_bad, output int stb_bad, output int n_deser,
                             output int n_par, output int n_strt, output int n_stp,
                             output int dv_n, output int dv_k);
        int  half, b, total, kend, ks, kp, kt, ee, eb;
        bit  pe, ea, es;
        logic [11:0] fr;
        pe = pen && PAR_BUILD;
        b = DW + 2 + int'(pe);
        total = glitch ? p : b * p;
        kend = early ? total + 2 : total + 3;
        half = p / 2;
        ks = half + 3;
        kp = (DW + 1) * p + half + 3;
        kt = (b - 1) * p + half + 3;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = dat;
        if (pe) fr[9] = ^dat;
        trk_bad = 0; stb_bad = 0; n_deser = 0; n_par = 0; n_strt = 0; n_stp = 0;
        dv_n = 0; dv_k = -1;
        Prescale = PW'(p);
        PAR_EN = pen;
        RX_IN = 1'b0;
        for (int k = 1; k <= kend; k++) begin
            tick();
            ea = 1'b0; ee = 0; eb = 0;
            if (k <= total) begin
                ea = 1'b1; ee = (k - 1) % p; eb = (k - 1) / p;
            end else if (early && k >= total + 2) begin
                ea = 1'b1; ee = k - total - 2; eb = 0;
            end
            if (edge_cnt !== PW'(ee) || bit_cnt !== 4'(eb) || dat_samp_en !== ea) begin
                if (trk_bad == 0)
                    $display("  cycle N+%0d: edge_cnt=%0d bit_cnt=%0d samp=%0b want %0d/%0d/%0b",
                             k, edge_cnt, bit_cnt, dat_samp_en, ee, eb, ea);
                trk_bad++;
            end
            es = ea && (k <= total) && (ee == half + 2);
            if ({strt_chk_en, deser_en, par_chk_en, stp_chk_en} !==
                {es && eb == 0, es && eb >= 1 && eb <= DW, es && pe && eb == DW + 1,
                 es && !glitch && eb == b - 1})
                stb_bad++;
            n_strt  += int'(strt_chk_en);
            n_deser += int'(deser_en);
            n_par   += int'(par_chk_en);
            n_stp   += int'(stp_chk_en);
            if (data_valid === 1'b1) begin dv_n++; dv_k = k; end
            if (k == 4) PAR_EN = !pen;
            if (glitch)                   RX_IN = (k < 2) ? 1'b0 : 1'b1;
            else if (early && k >= total) RX_IN = 1'b0;
            else if (k < total)           RX_IN = fr[k / p];
            else                          RX_IN = 1'b1;
            strt_glitch = glitch && k > ks && k <= total;
            par_err     = perr && k <= total && (pe ? k > kp : 1'b1);
            stp_err     = serr && !glitch && k > kt && k <= total;
        end
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        if (!early) RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        int tb, sb, nd, np, ns, nt, dn, dk, act;
        logic [PW+9:0] outs;
        outs = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid};
        n_total++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else n_pass++;
        tick(); RST = 1'b1;
        tick(); tick();
        RX_IN = 1'b0;
        for (int i = 0; i < 30; i++) begin tick(); RX_IN = (i < 6) ? 1'b0 : 1'b1; end
        n_total++;
        if (dat_samp_en !== 1'b1) $display("FAIL reset_frame_running: samp=%0b want 1", dat_samp_en); else n_pass++;
        #2 RST = 1'b0;
        #1;
        outs = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid};
        n_total++;
        if (outs !== '0) $display("FAIL reset_midframe: got %h want 0", outs); else n_pass++;
        tick(); tick(); RST = 1'b1;
        act = 0;
        for (int i = 0; i < 90; i++) begin
            tick();
            act += int'(data_valid) + int'(dat_samp_en);
        end
        n_total++;
        if (act !== 0) $display("FAIL reset_no_partial_dv: active cycles %0d want 0", act); else n_pass++;
        run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (dk !== 81 || dn !== 1) $display("FAIL reset_next_frame: dv at N+%0d x%0d want N+81 x1", dk, dn); else n_pass++;
    endtask

    task automatic test_clean_no_parity();
        int tb, sb, nd, np, ns, nt, dn, dk;
        run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (tb !== 0) $display("FAIL p8_tracking: %0d bad cycles want 0", tb); else n_pass++;
        n_total++;
        if (sb !== 0) $display("FAIL p8_strobe_timing: %0d bad cycles want 0", sb); else n_pass++;
        n_total++;
        if (nd !== 8) $display("FAIL p8_deser_count: got %0d want 8", nd); else n_pass++;
        n_total++;
        if (ns !== 1 || nt !== 1 || np !== 0) $display("FAIL p8_chk_counts: strt=%0d stp=%0d par=%0d want 1/1/0", ns, nt, np); else n_pass++;
        n_total++;
        if (dk !== 81 || dn !== 1) $display("FAIL p8_dv_latency: dv at N+%0d x%0d want N+81 x1", dk, dn); else n_pass++;
    endtask

    task automatic test_clean_parity();
        int tb, sb, nd, np, ns, nt, dn, dk;
        run_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (tb !== 0 || sb !== 0) $display("FAIL p16_par_timing: track %0d strobe %0d want 0/0", tb, sb); else n_pass++;
        n_total++;
        if (np !== (PAR_BUILD ? 1 : 0)) $display("FAIL p16_par_chk_count: got %0d want %0d", np, PAR_BUILD ? 1 : 0); else n_pass++;
        n_total++;
        if (dk !== (PAR_BUILD ? 177 : 161) || dn !== 1)
            $display("FAIL p16_dv_latency: dv at N+%0d x%0d want N+%0d x1", dk, dn, PAR_BUILD ? 177 : 161);
        else n_pass++;
    endtask

    task automatic test_false_start();
        int tb, sb, nd, np, ns, nt, dn, dk;
        run_frame(8, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (tb !== 0) $display("FAIL glitch_back_to_idle: %0d bad cycles want 0", tb); else n_pass++;
        n_total++;
        if (nd !== 0 || dn !== 0 || ns !== 1) $display("FAIL glitch_no_frame: deser=%0d dv=%0d strt=%0d want 0/0/1", nd, dn, ns); else n_pass++;
    endtask

    task automatic test_bad_par_stop();
        int tb, sb, nd, np, ns, nt, dn, dk;
        run_frame(16, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (dn !== (PAR_BUILD ? 0 : 1) || tb !== 0)
            $display("FAIL bad_parity_frame: dv %0d track %0d want %0d/0", dn, tb, PAR_BUILD ? 0 : 1);
        else n_pass++;
        run_frame(16, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (dn !== 0 || nt !== 1 || tb !== 0) $display("FAIL bad_stop_frame: dv %0d stp %0d track %0d want 0/1/0", dn, nt, tb); else n_pass++;
        run_frame(16, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (dk !== (PAR_BUILD ? 177 : 161) || dn !== 1)
            $display("FAIL recover_after_errors: dv at N+%0d x%0d want N+%0d x1", dk, dn, PAR_BUILD ? 177 : 161);
        else n_pass++;
    endtask

    task automatic test_prescale32();
        int tb, sb, nd, np, ns, nt, dn, dk;
        run_frame(32, !PAR_BUILD, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (tb !== 0 || sb !== 0 || np !== 0) $display("FAIL p32_no_parity: track %0d strobe %0d par %0d want 0/0/0", tb, sb, np); else n_pass++;
        n_total++;
        if (dk !== 321 || dn !== 1) $display("FAIL p32_dv_latency: dv at N+%0d x%0d want N+321 x1", dk, dn); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int tb, sb, nd, np, ns, nt, dn, dk;
        run_frame(8, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, tb, sb, nd, np, ns, nt, dn, dk);
        n_total++;
        if (tb !== 0) $display("FAIL stop_exit_low_rx: %0d bad cycles want 0", tb); else n_pass++;
        n_total++;
        if (dk !== 81 || dn !== 1) $display("FAIL stop_exit_dv: dv at N+%0d x%0d want N+81 x1", dk, dn); else n_pass++;
        RX_IN = 1'b1;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_clean_no_parity();
        test_clean_parity();
        test_false_start();
        test_bad_par_stop();
        test_prescale32();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
